// File: rtl/counter_nb_pkg.sv
// Shared constants and helpers for the counter_nb modulo-N counter family.
// Load clamping is done at the widest legal width (33 bits) and truncated by the caller.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int unsigned MAX_WIDTH = 32;

    typedef logic [MAX_WIDTH:0] cnt_wide_t;

    function automatic cnt_wide_t clamp_load(input cnt_wide_t d, input cnt_wide_t modulus);
        return (d >= modulus) ? (modulus - cnt_wide_t'(1)) : d;
    endfunction

endpackage

// File: rtl/counter_nb_next.sv
// Next-count, terminal-count and wrap-event logic for counter_nb (purely combinational).
// Latency: zero. No backpressure. COUNTER_NB_SAT_EN selects saturate instead of wrap.
module counter_nb_next
    import counter_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] nxt,
    output logic             term,
    output logic             wrap
);

    // One extra bit so MODULUS-1 and q+1 never overflow when MODULUS = 2**WIDTH.
    localparam logic [WIDTH:0] TOP = (WIDTH+1)'(MODULUS - 64'd1);
    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0] q_w;
    logic           near;

    assign q_w  = {1'b0, q};
    assign term = (up == DIR_UP) ? (q_w == TOP) : (q_w == '0);
    assign near = (up == DIR_UP) ? ((q_w + ONE) == TOP) : (q_w == ONE);

    always_comb begin
        nxt  = q;
        wrap = 1'b0;
        if (ld) begin
            nxt = WIDTH'(clamp_load(cnt_wide_t'(d), cnt_wide_t'(MODULUS)));
        end else if (en) begin
            if (term) begin
`ifdef COUNTER_NB_SAT_EN
                nxt  = q;
                wrap = 1'b0;
`else
                nxt  = (up == DIR_UP) ? '0 : WIDTH'(TOP);
                wrap = 1'b1;
`endif
            end else begin
                nxt = (up == DIR_UP) ? WIDTH'(q_w + ONE) : WIDTH'(q_w - ONE);
`ifdef COUNTER_NB_SAT_EN
                // Saturating: the event is arriving at the terminal value, not leaving it.
                wrap = near;
`else
                wrap = 1'b0;
`endif
            end
        end
    end

endmodule

// File: rtl/counter_nb.sv
// Parametrised up/down modulo-N counter with load, enable, cascade rc and registered tc.
// Latency: q/tc one clock, rc zero. No backpressure. COUNTER_NB_SAT_EN selects saturating mode.
module counter_nb
    import counter_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rc,
    output logic             tc
);

    logic [WIDTH-1:0] q_nxt;
    logic             term;
    logic             wrap;

    counter_nb_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q    (q),
        .up   (up),
        .en   (en),
        .ld   (ld),
        .d    (d),
        .nxt  (q_nxt),
        .term (term),
        .wrap (wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q  <= '0;
            tc <= 1'b0;
        end else begin
            q  <= q_nxt;
            tc <= wrap;
        end
    end

    // Combinational so the next stage's enable sees the carry in the same cycle.
    assign rc = en && term;

endmodule

// File: tb/tb_counter_nb.sv
// Bench for counter_nb: five instances (mod 16, mod 10, cascaded mod-10 pair, 3-bit mod 5)
// against a behavioural model, with directed literal checks and a randomized phase.
module tb_counter_nb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       up  = 1'b1;
    logic       ld  = 1'b0;
    logic [3:0] d   = '0;

    logic [3:0] q0, q1, q2, q3;
    logic [2:0] q4;
    logic       rc0, rc1, rc2, rc3, rc4;
    logic       tc0, tc1, tc2, tc3, tc4;

    always #5 clk = ~clk;

    counter_nb #(.WIDTH(4), .MODULUS(16)) u0 (.clk(clk), .rst(rst), .en(en), .up(up), .ld(ld), .d(d), .q(q0), .rc(rc0), .tc(tc0));
    counter_nb #(.WIDTH(4), .MODULUS(10)) u1 (.clk(clk), .rst(rst), .en(en), .up(up), .ld(ld), .d(d), .q(q1), .rc(rc1), .tc(tc1));
    counter_nb #(.WIDTH(4), .MODULUS(10)) u2 (.clk(clk), .rst(rst), .en(en), .up(up), .ld(ld), .d(d), .q(q2), .rc(rc2), .tc(tc2));
    counter_nb #(.WIDTH(4), .MODULUS(10)) u3 (.clk(clk), .rst(rst), .en(rc2), .up(up), .ld(ld), .d(d), .q(q3), .rc(rc3), .tc(tc3));
    counter_nb #(.WIDTH(3), .MODULUS(5))  u4 (.clk(clk), .rst(rst), .en(en), .up(up), .ld(ld), .d(d[2:0]), .q(q4), .rc(rc4), .tc(tc4));

    logic [3:0] qa  [5];
    logic       rca [5];
    logic       tca [5];
    always_comb begin
        qa[0] = q0; qa[1] = q1; qa[2] = q2; qa[3] = q3; qa[4] = {1'b0, q4};
        rca[0] = rc0; rca[1] = rc1; rca[2] = rc2; rca[3] = rc3; rca[4] = rc4;
        tca[0] = tc0; tca[1] = tc1; tca[2] = tc2; tca[3] = tc3; tca[4] = tc4;
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int mods [5] = '{16, 10, 10, 10, 5};
    int mq   [5];
    bit mtc  [5];

    function automatic bit m_term(int i);
        return up ? (mq[i] == mods[i] - 1) : (mq[i] == 0);
    endfunction

    function automatic bit m_en(int i);
        return (i == 3) ? (en && m_term(2)) : en;
    endfunction

    task automatic m_step(input int i, input bit e);
        int m;
        int dv;
        m  = mods[i];
        dv = (i == 4) ? (int'(d) % 8) : int'(d);
        mtc[i] = 1'b0;
        if (ld) begin
            mq[i] = (dv >= m) ? m - 1 : dv;
        end else if (e) begin
            if (up) begin
                if (mq[i] == m - 1) begin
`ifndef COUNTER_NB_SAT_EN
                    mq[i] = 0;
                    mtc[i] = 1'b1;
`endif
                end else begin
                    mq[i] = mq[i] + 1;
`ifdef COUNTER_NB_SAT_EN
                    mtc[i] = (mq[i] == m - 1);
`endif
                end
            end else begin
                if (mq[i] == 0) begin
`ifndef COUNTER_NB_SAT_EN
                    mq[i] = m - 1;
                    mtc[i] = 1'b1;
`endif
                end else begin
                    mq[i] = mq[i] - 1;
`ifdef COUNTER_NB_SAT_EN
                    mtc[i] = (mq[i] == 0);
`endif
                end
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        bit e [5];
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                mq[i]  = 0;
                mtc[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 5; i++) e[i] = m_en(i);
            for (int i = 0; i < 5; i++) m_step(i, e[i]);
        end
    end

    // ---------------- compare process ----------------
    bit chk_on = 1'b0;
    always @(negedge clk) begin
        if (chk_on && !rst) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("model_q%0d", i),  32'(qa[i]),  32'(mq[i]));
                check($sformatf("model_tc%0d", i), 32'(tca[i]), 32'(mtc[i]));
                check($sformatf("model_rc%0d", i), 32'(rca[i]), 32'(m_en(i) && m_term(i)));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        ld  = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        do_reset();
        chk_on = 1'b1;
        #1;
        check("reset_q0", 32'(q0), 0);
        check("reset_tc0", 32'(tc0), 0);
        check("reset_rc0", 32'(rc0), 0);

        // Mod-16 up count from reset
        up = 1'b1; en = 1'b1;
        repeat (15) tick();
        check("up16_q15", 32'(q0), 15);
        check("up16_rc_at15", 32'(rc0), 1);
`ifndef COUNTER_NB_SAT_EN
        check("up16_tc_before_wrap", 32'(tc0), 0);
        tick();
        check("up16_wrap_q", 32'(q0), 0);
        check("up16_wrap_tc", 32'(tc0), 1);
        check("up16_rc_after_wrap", 32'(rc0), 0);
        tick();
        check("up16_q1", 32'(q0), 1);
        check("up16_tc_drop", 32'(tc0), 0);
`else
        check("sat_tc_reach", 32'(tc0), 1);
        tick();
        check("sat_hold_q", 32'(q0), 15);
        check("sat_tc_once", 32'(tc0), 0);
        check("sat_rc_hold", 32'(rc0), 1);
        up = 1'b0;
        #1;
        check("sat_rc_dirflip", 32'(rc0), 0);
        tick();
        check("sat_down_q14", 32'(q0), 14);
        tick();
        check("sat_down_q13", 32'(q0), 13);
`endif

        // Mod-10 down count after reset
        do_reset();
        up = 1'b0; en = 1'b1;
        #1;
        check("down10_rc_at0", 32'(rc1), 1);
        tick();
`ifndef COUNTER_NB_SAT_EN
        check("down10_wrap_q9", 32'(q1), 9);
        check("down10_wrap_tc", 32'(tc1), 1);
        tick();
        check("down10_q8", 32'(q1), 8);
        check("down10_tc_drop", 32'(tc1), 0);
`else
        check("sat_down_hold0", 32'(q1), 0);
        check("sat_down_tc0", 32'(tc1), 0);
`endif

        // Load clamp and load-over-count priority
        ld = 1'b1; d = 4'd12; en = 1'b0;
        tick();
        check("load_clamp_m10", 32'(q1), 9);
        check("load_nomclamp_m16", 32'(q0), 12);
        check("load_tc0", 32'(tc1), 0);
        d = 4'd3; en = 1'b1; up = 1'b1;
        #1;
        check("load_rc_at_term", 32'(rc1), 1);
        tick();
        check("load_wins_q", 32'(q1), 3);
        check("load_wins_tc", 32'(tc1), 0);
        ld = 1'b0;

        // Two cascaded mod-10 stages
        do_reset();
        en = 1'b1; up = 1'b1;
        repeat (99) tick();
`ifndef COUNTER_NB_SAT_EN
        check("casc_q0_99", 32'(q2), 9);
        check("casc_q1_99", 32'(q3), 9);
        check("casc_rc1_99", 32'(rc3), 1);
        tick();
        check("casc_q0_wrap", 32'(q2), 0);
        check("casc_q1_wrap", 32'(q3), 0);
        check("casc_tc0", 32'(tc2), 1);
        check("casc_tc1", 32'(tc3), 1);
`endif

        // Asynchronous reset between edges
        do_reset();
        en = 1'b1; up = 1'b1;
        repeat (7) tick();
        check("arst_pre_q7", 32'(q0), 7);
        #1 rst = 1'b1;
        #1;
        check("arst_q_immediate", 32'(q0), 0);
        check("arst_tc_immediate", 32'(tc0), 0);
        #1 rst = 1'b0;
        tick();
        check("arst_resume_q1", 32'(q0), 1);
        tick();
        check("arst_resume_q2", 32'(q0), 2);

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 9) < 7);
            up  = ($urandom_range(0, 3) != 0);
            ld  = ($urandom_range(0, 15) == 0);
            d   = 4'($urandom_range(0, 15));
            if ((n % 500) == 250) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
            tick();
        end
        rst = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
